// File: rtl/sw_cond_pkg.sv
// Shared types and defaults for the switch conditioner.
package sw_cond_pkg;

  typedef enum logic {DB_STABLE, DB_CHECK} db_state_t;

  localparam int unsigned DB_CYCLES_DEF   = 1_000_000;
  localparam int unsigned TICK_CYCLES_DEF = 25_000_000;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_1b.sv
// Single-bit synchroniser plus debounce FSM.
// SW_COND_EDGE_EN adds registered rise/fall pulses aligned with q.
module sw_debounce_1b
  import sw_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic q,
`ifdef SW_COND_EDGE_EN
  output logic rise,
  output logic fall,
`endif
  output logic upd
);

  localparam int unsigned CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  db_state_t              state_q;
  logic [CW-1:0]          cnt_q;
  logic                   q_q;
  logic                   sw_s;

  assign sw_s = sync_q[SYNC_STAGES-1];
  assign q    = q_q;

  // upd marks the edge at which q takes sw_s; the top uses it to restart the tick counter.
  // A one-cycle debounce latches straight from DB_STABLE, since DB_CHECK could never match cnt=0.
  assign upd = (sw_s != q_q) &&
               ((state_q == DB_CHECK && cnt_q == LAST) || (DB_CYCLES == 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
      unique case (state_q)
        DB_STABLE: begin
          if (sw_s != q_q) begin
            if (DB_CYCLES == 1) begin
              q_q <= sw_s;
            end else begin
              state_q <= DB_CHECK;
              cnt_q   <= CW'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        DB_CHECK: begin
          if (sw_s == q_q) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            q_q     <= sw_s;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

`ifdef SW_COND_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= upd & sw_s;
      fall_q <= upd & ~sw_s;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: rtl/sw_conditioner.sv
// Switch synchronise/debounce front-end with restartable count-enable tick.
// SW_COND_EDGE_EN adds sw_rise/sw_fall edge-pulse outputs.
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int unsigned N_SW        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
`ifdef SW_COND_EDGE_EN
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
`endif
  output logic            tick
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_CYCLES - 1);

  logic [N_SW-1:0] upd;
  logic [TW-1:0]   tcnt_q;
  logic            tick_q;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    sw_debounce_1b #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .d_raw (sw_raw[g]),
      .q     (sw_db[g]),
`ifdef SW_COND_EDGE_EN
      .rise  (sw_rise[g]),
      .fall  (sw_fall[g]),
`endif
      .upd   (upd[g])
    );
  end

  // A change on any debounced switch restarts the period and overrides a due wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else if (|upd) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else if (tcnt_q == TLAST) begin
      tcnt_q <= '0;
      tick_q <= 1'b1;
    end else begin
      tcnt_q <= tcnt_q + TW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner: directed scenarios plus random switch activity
// against a run-length behavioural model.
module tb_sw_conditioner;

  localparam int NSW = 2;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int TC  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw_raw;
  logic [1:0] sw_db;
  logic       tick;
`ifdef SW_COND_EDGE_EN
  logic [1:0] sw_rise, sw_fall;
  int         rcnt1, fcnt1;
`endif

  always #5 clk = ~clk;

  sw_conditioner #(
    .N_SW        (NSW),
    .SYNC_STAGES (SS),
    .DB_CYCLES   (DB),
    .TICK_CYCLES (TC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_db   (sw_db),
`ifdef SW_COND_EDGE_EN
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
`endif
    .tick    (tick)
  );

  // Model: raw history delayed SS cycles; a switch's level is accepted once the
  // synchronised input has disagreed with it for DB consecutive cycles.
  logic [1:0] hist [SS];
  int         run_m [2];
  logic [1:0] db_m, rise_m, fall_m;
  int         tcnt_m;
  logic       tick_m;

  always @(posedge clk or negedge rst_n) begin : model
    logic [1:0] sws, nd;
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) hist[i] = '0;
      for (int i = 0; i < 2; i++) run_m[i] = 0;
      db_m = '0; rise_m = '0; fall_m = '0; tcnt_m = 0; tick_m = 1'b0;
    end else begin
      sws = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw_raw;
      nd = db_m;
      for (int i = 0; i < 2; i++) begin
        if (sws[i] != db_m[i]) begin
          run_m[i]++;
          if (run_m[i] == DB) begin
            nd[i] = sws[i];
            run_m[i] = 0;
          end
        end else begin
          run_m[i] = 0;
        end
      end
      rise_m = nd & ~db_m;
      fall_m = ~nd & db_m;
      if (nd != db_m) begin
        tcnt_m = 0; tick_m = 1'b0;
      end else if (tcnt_m == TC - 1) begin
        tcnt_m = 0; tick_m = 1'b1;
      end else begin
        tcnt_m++; tick_m = 1'b0;
      end
      db_m = nd;
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq("db", 32'(sw_db), 32'(db_m));
      check_eq("tick", 32'(tick), 32'(tick_m));
`ifdef SW_COND_EDGE_EN
      check_eq("rise", 32'(sw_rise), 32'(rise_m));
      check_eq("fall", 32'(sw_fall), 32'(fall_m));
      rcnt1 += int'(sw_rise[1]);
      fcnt1 += int'(sw_fall[1]);
`endif
    end
  endtask

  task automatic wait_tcnt(input int v, input string tag);
    for (int w = 0; w < 2 * TC && tcnt_m != v; w++) step(1);
    check_eq(tag, 32'(tcnt_m), 32'(v));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    sw_raw = 2'b11;
    // 1: reset then release with both switches held
    step(3);
    check_eq("rst_db", 32'(sw_db), 32'h0);
    check_eq("rst_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;
    step(4);
    check_eq("rel_notick4", 32'(tick), 32'h0);
    step(1);
    check_eq("rel_tick5", 32'(tick), 32'h1);
    check_eq("rel_db5", 32'(sw_db), 32'h0);
    step(1);
    check_eq("rel_db6", 32'(sw_db), 32'h3);
    check_eq("rel_tick6", 32'(tick), 32'h0);
    step(4);
    check_eq("rel_notick10", 32'(tick), 32'h0);
    step(1);
    check_eq("rel_tick11", 32'(tick), 32'h1);
    sw_raw = 2'b00;
    step(12);

    // 2: clean press on switch 0
    sw_raw[0] = 1'b1;
    step(5);
    check_eq("press_pre", 32'(sw_db[0]), 32'h0);
    step(1);
    check_eq("press_db0", 32'(sw_db[0]), 32'h1);
    check_eq("press_db1", 32'(sw_db[1]), 32'h0);
    step(8);

    // 3: bounce pattern 1,1,1,0 never qualifies
    sw_raw[0] = 1'b0;
    step(12);
    for (int c = 0; c < 40; c++) begin
      sw_raw[0] = (c % 4 != 3);
      step(1);
      check_eq("bounce_db0", 32'(sw_db[0]), 32'h0);
    end
    sw_raw[0] = 1'b0;
    step(10);

    // 4a: change lands while the tick counter is 3
    wait_tcnt(3, "align3");
    sw_raw[0] = 1'b1;
    step(6);
    check_eq("restart_db0", 32'(sw_db[0]), 32'h1);
    check_eq("restart_tick0", 32'(tick), 32'h0);
    step(4);
    check_eq("restart_pre", 32'(tick), 32'h0);
    step(1);
    check_eq("restart_next", 32'(tick), 32'h1);
    step(5);
    check_eq("restart_period", 32'(tick), 32'h1);

    // 4b: change lands exactly when a wrap is due
    wait_tcnt(4, "align4");
    sw_raw[0] = 1'b0;
    step(6);
    check_eq("wrap_db0", 32'(sw_db[0]), 32'h0);
    check_eq("wrap_suppressed", 32'(tick), 32'h0);
    step(5);
    check_eq("wrap_next", 32'(tick), 32'h1);

    // 5: asynchronous reset while switch 0 is mid-check
    sw_raw = 2'b10;
    step(12);
    sw_raw = 2'b11;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_db", 32'(sw_db), 32'h0);
    check_eq("arst_tick", 32'(tick), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(5);
    check_eq("arst_rel_pre", 32'(sw_db), 32'h0);
    step(1);
    check_eq("arst_rel_db", 32'(sw_db), 32'h3);
    sw_raw = 2'b00;
    step(12);

`ifdef SW_COND_EDGE_EN
    // 6: one rise and one fall on switch 1, none under bounce
    rcnt1 = 0;
    fcnt1 = 0;
    sw_raw[1] = 1'b1;
    step(10);
    sw_raw[1] = 1'b0;
    step(10);
    for (int c = 0; c < 40; c++) begin
      sw_raw[1] = (c % 4 != 3);
      step(1);
    end
    sw_raw[1] = 1'b0;
    step(8);
    check_eq("edge_rise_cnt", 32'(rcnt1), 32'h1);
    check_eq("edge_fall_cnt", 32'(fcnt1), 32'h1);
`endif

    // Random switch activity with occasional asynchronous resets
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(5) == 0) sw_raw[b] = ~sw_raw[b];
      if ($urandom_range(299) == 0) begin
        #($urandom_range(3) + 1) rst_n = 1'b0;
        #1;
        check_eq("rand_arst_db", 32'(sw_db), 32'h0);
        step(1 + $urandom_range(2));
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
